matrix_reader: RTL and testbench
================================

MATRIX_READER -- requirements
Module: matrix_reader

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 1152, meaning BRAM words reserved per matrix slot.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning BRAM word and element width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 14, meaning BRAM address width.
REQ-004 SHALL use one clock, clk (input, 1), with every flop rising-edge.
REQ-005 SHALL use reset rst_n (input, 1), asynchronous, active-low.
REQ-006 SHALL have read_request (input, 1): start a read; sampled only in IDLE.
REQ-007 SHALL have matrix_id (input, 3): slot to read; latched when the request is accepted.
REQ-008 SHALL have read_ready (output, 1): high only in IDLE.
REQ-009 SHALL have meta_valid (output, 1): one-cycle pulse qualifying the metadata outputs.
REQ-010 SHALL have actual_rows and actual_cols (outputs, 8 each): dimensions read from metadata.
REQ-011 SHALL have matrix_name (output, 8 x 8-bit array, indices 0..7): name bytes.
REQ-012 SHALL have data_out (output, DATA_WIDTH), data_valid (output, 1) and data_ready (input, 1): element stream with valid/ready handshake.
REQ-013 SHALL have read_done (output, 1) and size_error (output, 1): one-cycle completion and error pulses.
REQ-014 SHALL have bram_rd_en (output, 1), bram_addr (output, ADDR_WIDTH) and bram_dout (input, DATA_WIDTH): synchronous BRAM read port with 1-cycle latency.

Function
REQ-015 SHALL compute base = matrix_id*BLOCK_SIZE; slot layout: word0 = {rows[31:24], cols[23:16], zero[15:0]}; word1 = name[0..3], name[0] in [31:24]; word2 = name[4..7]; data from base+3, row-major.
REQ-016 SHALL implement the states IDLE, META_RD, META_CAP, META_OUT, DATA_RD, DATA_WAIT, DATA_HOLD and DONE.
REQ-017 SHALL, in IDLE with read_request high, latch matrix_id and enter META_RD.
REQ-018 SHALL, in META_RD, issue reads of base, base+1 and base+2 on 3 consecutive cycles; each word is captured the cycle after its issue; after the third issue it enters META_CAP.
REQ-019 SHALL, in META_CAP, capture word2 and enter META_OUT.
REQ-020 SHALL, in META_OUT, pulse meta_valid for one cycle with all metadata outputs stable and held until the next request.
REQ-021 SHALL compute total = rows*cols at 16 bits with no truncation.
REQ-022 SHALL, from META_OUT, go to DONE when total == 0 (no data beats), and pulse size_error then go to DONE when total > BLOCK_SIZE-3; otherwise it enters DATA_RD.
REQ-023 SHALL, in DATA_RD, issue one read at the current address and enter DATA_WAIT.
REQ-024 SHALL, in DATA_WAIT, register bram_dout into data_out, assert data_valid and enter DATA_HOLD.
REQ-025 SHALL, in DATA_HOLD, hold data_valid and data_out stable while data_ready is low.
REQ-026 SHALL, on a DATA_HOLD cycle with data_ready high, drop data_valid, increment the count and address, and go to DONE when count+1 == total, else to DATA_RD.
REQ-027 SHALL sustain a minimum of 3 cycles per element.
REQ-028 SHALL, in DONE, pulse read_done for one cycle and return to IDLE.
REQ-029 SHALL register all outputs except read_ready.
REQ-030 SHALL hold bram_rd_en low except on issue cycles.
REQ-031 SHALL ignore read_request outside IDLE.
REQ-032 SHALL ignore data_ready while data_valid is low.

Reset
REQ-033 SHALL, while rst_n is low, hold the FSM in IDLE, all counters at 0 and all registered outputs at 0, including matrix_name bytes; read_ready is therefore 1.
REQ-034 SHALL, on reset mid-operation, abandon the transfer with no read_done pulse and respond to a new request in the first cycle after deassertion.

Structure
REQ-035 SHALL place the FSM state enum and the constant META_WORDS = 3 in the shared matrix BRAM package used by the writer side.
REQ-036 SHALL instantiate matrix_address_getter for base-address generation; no other sub-modules.

Verification
REQ-037 SHALL verify basic read: slot 2 preloaded as 2x3, name "MATRIX_A", data 1..6 -> meta_valid shows rows=2, cols=3 and the name; 6 beats in order from address 2307; read_done follows.
REQ-038 SHALL verify backpressure: data_ready low for 5 cycles on beat 3 -> data_out stable, no extra BRAM reads, and no loss or duplication.
REQ-039 SHALL verify empty matrix: rows=0 -> meta_valid, zero data beats, read_done exactly 2 cycles after meta_valid.
REQ-040 SHALL verify oversize: slot 0 with rows=cols=255 (total 65025) -> one size_error pulse, zero data beats, then read_done.
REQ-041 SHALL verify mid-read reset: rst_n pulsed low during beat 4 -> all outputs 0, no read_done; a following request for slot 5 completes correctly.
REQ-042 SHALL verify writer round-trip: the writer stores a 4x4 matrix in slot 1, then the reader returns an identical 16 beats and the same metadata.

Source files
------------

// File: rtl/matrix_bram_pkg.sv
// Shared definitions for the matrix BRAM slot layout, used by both the
// reader and writer sides.
package matrix_bram_pkg;

    // Header words at the start of every slot: dims, name[0..3], name[4..7].
    localparam int META_WORDS = 3;

    typedef enum logic [2:0] {
        IDLE,
        META_RD,
        META_CAP,
        META_OUT,
        DATA_RD,
        DATA_WAIT,
        DATA_HOLD,
        DONE
    } rd_state_t;

endpackage

// File: rtl/matrix_address_getter.sv
// Base address of a matrix slot: matrix_id * BLOCK_SIZE.
module matrix_address_getter #(
    parameter int BLOCK_SIZE = 1152,
    parameter int ADDR_WIDTH = 14
) (
    input  logic [2:0]            matrix_id,
    output logic [ADDR_WIDTH-1:0] base_addr
);

    assign base_addr = ADDR_WIDTH'(32'(matrix_id) * BLOCK_SIZE);

endmodule

// File: rtl/matrix_reader.sv
// Reads one matrix slot from BRAM: three header words, then rows*cols
// elements streamed out over a valid/ready handshake.
module matrix_reader
    import matrix_bram_pkg::*;
#(
    parameter int BLOCK_SIZE = 1152,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_request,
    input  logic [2:0]            matrix_id,
    output logic                  read_ready,
    output logic                  meta_valid,
    output logic [7:0]            actual_rows,
    output logic [7:0]            actual_cols,
    output logic [7:0]            matrix_name [0:7],
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  read_done,
    output logic                  size_error,
    output logic                  bram_rd_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    rd_state_t             state_q, state_d;
    logic [2:0]            id_q, id_d;
    logic [1:0]            meta_cnt_q, meta_cnt_d;
    logic [15:0]           elem_cnt_q, elem_cnt_d;
    logic [7:0]            rows_q, rows_d, cols_q, cols_d;
    logic [7:0]            name_q [0:7];
    logic [7:0]            name_d [0:7];
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_en_q, rd_en_d;
    logic                  meta_valid_q, meta_valid_d;
    logic                  data_valid_q, data_valid_d;
    logic                  read_done_q, read_done_d;
    logic                  size_error_q, size_error_d;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [15:0]           total;

    // Fed with the next id so the first header read can go out on the
    // cycle right after the request is accepted.
    matrix_address_getter #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr (
        .matrix_id(id_d),
        .base_addr(base_addr)
    );

    assign total = {8'd0, rows_q} * {8'd0, cols_q};

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case leaves it unassigned and infers a latch.
        state_d      = state_q;
        id_d         = id_q;
        meta_cnt_d   = meta_cnt_q;
        elem_cnt_d   = elem_cnt_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        name_d       = name_q;
        data_d       = data_q;
        addr_d       = addr_q;
        rd_en_d      = 1'b0;
        meta_valid_d = 1'b0;
        data_valid_d = data_valid_q;
        read_done_d  = 1'b0;
        size_error_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (read_request) begin
                    id_d       = matrix_id;
                    meta_cnt_d = '0;
                    elem_cnt_d = '0;
                    rd_en_d    = 1'b1;
                    state_d    = META_RD;
                end
            end
            META_RD: begin
                // bram_dout carries the word issued on the previous cycle.
                if (meta_cnt_q == 2'd1) begin
                    rows_d = bram_dout[31:24];
                    cols_d = bram_dout[23:16];
                end else if (meta_cnt_q == 2'd2) begin
                    name_d[0] = bram_dout[31:24];
                    name_d[1] = bram_dout[23:16];
                    name_d[2] = bram_dout[15:8];
                    name_d[3] = bram_dout[7:0];
                end
                if (meta_cnt_q == 2'(META_WORDS - 1)) begin
                    state_d = META_CAP;
                end else begin
                    meta_cnt_d = meta_cnt_q + 2'd1;
                    rd_en_d    = 1'b1;
                end
            end
            META_CAP: begin
                name_d[4]    = bram_dout[31:24];
                name_d[5]    = bram_dout[23:16];
                name_d[6]    = bram_dout[15:8];
                name_d[7]    = bram_dout[7:0];
                meta_valid_d = 1'b1;
                state_d      = META_OUT;
            end
            META_OUT: begin
                if (total == 16'd0) begin
                    state_d = DONE;
                end else if (int'(total) > BLOCK_SIZE - META_WORDS) begin
                    size_error_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    rd_en_d = 1'b1;
                    state_d = DATA_RD;
                end
            end
            DATA_RD: begin
                state_d = DATA_WAIT;
            end
            DATA_WAIT: begin
                data_d       = bram_dout;
                data_valid_d = 1'b1;
                state_d      = DATA_HOLD;
            end
            DATA_HOLD: begin
                if (data_ready) begin
                    data_valid_d = 1'b0;
                    elem_cnt_d   = elem_cnt_q + 16'd1;
                    if (elem_cnt_d == total) begin
                        state_d = DONE;
                    end else begin
                        rd_en_d = 1'b1;
                        state_d = DATA_RD;
                    end
                end
            end
            DONE: begin
                read_done_d = 1'b1;
                state_d     = IDLE;
            end
        endcase

        if (rd_en_d) begin
            if (state_d == META_RD) begin
                addr_d = base_addr + ADDR_WIDTH'(meta_cnt_d);
            end else begin
                addr_d = base_addr + ADDR_WIDTH'(META_WORDS) + ADDR_WIDTH'(elem_cnt_d);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            id_q         <= '0;
            meta_cnt_q   <= '0;
            elem_cnt_q   <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            // NOTE: the name bytes are outputs, so they are cleared on reset like any other output register.
            for (int i = 0; i < 8; i++) begin
                name_q[i] <= '0;
            end
            data_q       <= '0;
            addr_q       <= '0;
            rd_en_q      <= 1'b0;
            meta_valid_q <= 1'b0;
            data_valid_q <= 1'b0;
            read_done_q  <= 1'b0;
            size_error_q <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every flop samples the pre-edge values computed above.
            state_q      <= state_d;
            id_q         <= id_d;
            meta_cnt_q   <= meta_cnt_d;
            elem_cnt_q   <= elem_cnt_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            name_q       <= name_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            rd_en_q      <= rd_en_d;
            meta_valid_q <= meta_valid_d;
            data_valid_q <= data_valid_d;
            read_done_q  <= read_done_d;
            size_error_q <= size_error_d;
        end
    end

    assign read_ready  = (state_q == IDLE);
    assign meta_valid  = meta_valid_q;
    assign actual_rows = rows_q;
    assign actual_cols = cols_q;
    assign matrix_name = name_q;
    assign data_out    = data_q;
    assign data_valid  = data_valid_q;
    assign read_done   = read_done_q;
    assign size_error  = size_error_q;
    assign bram_rd_en  = rd_en_q;
    assign bram_addr   = addr_q;

endmodule

// File: tb/tb_matrix_reader.sv
// Directed bench for matrix_reader: BRAM model, writer-side loader, stream
// monitor and hand-computed expectations.
module tb_matrix_reader;

    localparam int BLOCK_SIZE = 1152;
    localparam int DW         = 32;
    localparam int AW         = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          read_request = 1'b0;
    logic [2:0]    matrix_id = 3'd0;
    logic          data_ready = 1'b1;
    logic          read_ready, meta_valid, data_valid, read_done, size_error, bram_rd_en;
    logic [7:0]    actual_rows, actual_cols;
    logic [7:0]    matrix_name [0:7];
    logic [DW-1:0] data_out;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout = '0;

    always #5 clk = ~clk;

    matrix_reader #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .read_request(read_request),
        .matrix_id(matrix_id),
        .read_ready(read_ready),
        .meta_valid(meta_valid),
        .actual_rows(actual_rows),
        .actual_cols(actual_cols),
        .matrix_name(matrix_name),
        .data_out(data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .read_done(read_done),
        .size_error(size_error),
        .bram_rd_en(bram_rd_en),
        .bram_addr(bram_addr),
        .bram_dout(bram_dout)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (bram_rd_en) bram_dout <= mem[bram_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Stream monitor, sampled on the falling edge.
    int            cyc = 0;
    logic [DW-1:0] beats [$];
    logic [AW-1:0] rd_addrs [$];
    int            meta_n, done_n, serr_n, rd_n, unstable_n;
    int            meta_cyc, done_cyc, serr_cyc;
    logic [7:0]    m_rows, m_cols;
    logic [63:0]   m_name;
    logic          prev_valid = 1'b0;
    logic [DW-1:0] prev_data = '0;

    function automatic logic [63:0] pack_name(input logic [7:0] n [0:7]);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[55:0], n[i]};
        return r;
    endfunction

    function automatic logic [63:0] str64(input string s);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[55:0], s[i]};
        return r;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (meta_valid) begin
            meta_n++;
            meta_cyc = cyc;
            m_rows   = actual_rows;
            m_cols   = actual_cols;
            m_name   = pack_name(matrix_name);
        end
        if (read_done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (size_error) begin
            serr_n++;
            serr_cyc = cyc;
        end
        if (bram_rd_en) begin
            rd_n++;
            rd_addrs.push_back(bram_addr);
        end
        if (data_valid && prev_valid && data_out !== prev_data) unstable_n++;
        prev_valid = data_valid;
        prev_data  = data_out;
        if (data_valid && data_ready) beats.push_back(data_out);
    end

    // Consumer: drops data_ready for stall_left cycles when beat index stall_at is offered.
    int stall_at = -1;
    int stall_left = 0;

    always @(posedge clk) begin
        #1;
        if (data_valid && stall_left > 0 && beats.size() == stall_at) begin
            data_ready = 1'b0;
            stall_left--;
        end else begin
            data_ready = 1'b1;
        end
    end

    task automatic clear_mon();
        beats.delete();
        rd_addrs.delete();
        meta_n = 0; done_n = 0; serr_n = 0; rd_n = 0; unstable_n = 0;
        meta_cyc = 0; done_cyc = 0; serr_cyc = 0;
        m_rows = '0; m_cols = '0; m_name = '0;
    endtask

    // Writer side of the slot layout.
    task automatic load_slot(input int slot, input logic [7:0] r, input logic [7:0] c,
                             input string name, input logic [31:0] v0, input int step, input int n);
        int b = slot * BLOCK_SIZE;
        mem[b]     = {r, c, 16'h0000};
        mem[b + 1] = {name[0], name[1], name[2], name[3]};
        mem[b + 2] = {name[4], name[5], name[6], name[7]};
        for (int i = 0; i < n; i++) mem[b + 3 + i] = v0 + 32'(i * step);
    endtask

    task automatic start_read(input logic [2:0] id);
        @(posedge clk); #1;
        clear_mon();
        matrix_id    = id;
        read_request = 1'b1;
        @(posedge clk); #1;
        read_request = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 4000 && done_n == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_once"}, 64'(done_n), 64'd1);
    endtask

    task automatic check_meta(input string tag, input logic [7:0] r, input logic [7:0] c, input string name);
        check({tag, "_meta_pulses"}, 64'(meta_n), 64'd1);
        check({tag, "_rows"}, 64'(m_rows), 64'(r));
        check({tag, "_cols"}, 64'(m_cols), 64'(c));
        check({tag, "_name"}, m_name, str64(name));
    endtask

    task automatic check_beats(input string tag, input int n, input logic [31:0] v0, input int step);
        check({tag, "_beat_count"}, 64'(beats.size()), 64'(n));
        for (int i = 0; i < n && i < beats.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), 64'(beats[i]), 64'(v0 + 32'(i * step)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        load_slot(2, 8'd2,   8'd3,   "MATRIX_A", 32'd1,     1, 6);
        load_slot(3, 8'd0,   8'd5,   "EMPTY___", 32'd0,     0, 0);
        load_slot(0, 8'd255, 8'd255, "BIGGEST_", 32'd0,     0, 0);
        load_slot(6, 8'd25,  8'd46,  "OVER1150", 32'd0,     0, 0);
        load_slot(4, 8'd2,   8'd4,   "RESETME_", 32'h40,    1, 8);
        load_slot(5, 8'd3,   8'd2,   "SLOT5___", 32'hA0,    1, 6);
        clear_mon();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_read_ready", 64'(read_ready), 64'd1);
        check("rst_outputs", {58'd0, meta_valid, data_valid, read_done, size_error, bram_rd_en, 1'b0}, 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_dims", {48'd0, actual_rows, actual_cols}, 64'd0);
        check("rst_name", pack_name(matrix_name), 64'd0);
        rst_n = 1'b1;

        // Basic read of slot 2
        start_read(3'd2);
        wait_done("basic");
        check_meta("basic", 8'd2, 8'd3, "MATRIX_A");
        check_beats("basic", 6, 32'd1, 1);
        check("basic_rd_count", 64'(rd_n), 64'd9);
        if (rd_addrs.size() == 9) begin
            check("basic_addr_hdr", 64'(rd_addrs[0]), 64'd2304);
            check("basic_addr_first", 64'(rd_addrs[3]), 64'd2307);
            check("basic_addr_last", 64'(rd_addrs[8]), 64'd2312);
        end
        check("basic_no_size_error", 64'(serr_n), 64'd0);

        // Backpressure on beat 3
        stall_at   = 2;
        stall_left = 5;
        start_read(3'd2);
        wait_done("bp");
        check("bp_stall_applied", 64'(stall_left), 64'd0);
        check_beats("bp", 6, 32'd1, 1);
        check("bp_rd_count", 64'(rd_n), 64'd9);
        check("bp_data_stable", 64'(unstable_n), 64'd0);
        stall_at = -1;

        // Empty matrix
        start_read(3'd3);
        wait_done("empty");
        check_meta("empty", 8'd0, 8'd5, "EMPTY___");
        check("empty_beats", 64'(beats.size()), 64'd0);
        check("empty_done_gap", 64'(done_cyc - meta_cyc), 64'd2);
        check("empty_rd_count", 64'(rd_n), 64'd3);

        // Oversize 255x255
        start_read(3'd0);
        wait_done("big");
        check_meta("big", 8'd255, 8'd255, "BIGGEST_");
        check("big_size_error", 64'(serr_n), 64'd1);
        check("big_beats", 64'(beats.size()), 64'd0);
        check("big_err_before_done", 64'(done_cyc - serr_cyc), 64'd1);

        // Just over the limit: 1150 elements
        start_read(3'd6);
        wait_done("over");
        check("over_size_error", 64'(serr_n), 64'd1);
        check("over_beats", 64'(beats.size()), 64'd0);

        // Reset during beat 4, then slot 5 immediately after release
        start_read(3'd4);
        for (int i = 0; i < 500 && !(beats.size() == 3 && data_valid); i++) begin
            @(posedge clk); #1;
        end
        check("mid_reached_beat4", 64'(beats.size() == 3 && data_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {58'd0, meta_valid, data_valid, read_done, size_error, bram_rd_en, 1'b0}, 64'd0);
        check("mid_rst_data", 64'(data_out), 64'd0);
        check("mid_rst_meta", {pack_name(matrix_name) | {48'd0, actual_rows, actual_cols}}, 64'd0);
        check("mid_rst_ready", 64'(read_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("mid_no_done", 64'(done_n), 64'd0);
        clear_mon();
        rst_n        = 1'b1;
        matrix_id    = 3'd5;
        read_request = 1'b1;
        @(posedge clk); #1;
        read_request = 1'b0;
        check("mid_accept_first_cycle", 64'(read_ready), 64'd0);
        wait_done("mid");
        check_meta("mid", 8'd3, 8'd2, "SLOT5___");
        check_beats("mid", 6, 32'hA0, 1);

        // Writer round-trip: 4x4 into slot 1
        load_slot(1, 8'd4, 8'd4, "MAT4X4RT", 32'h1000, 7, 16);
        start_read(3'd1);
        wait_done("rt");
        check_meta("rt", 8'd4, 8'd4, "MAT4X4RT");
        check_beats("rt", 16, 32'h1000, 7);
        if (rd_addrs.size() > 3) check("rt_addr_first", 64'(rd_addrs[3]), 64'(BLOCK_SIZE + 3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
